// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: FSM state encoding, funct3 access codes, access decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MEM   = 2'b01,
    ST_FAULT = 2'b10
  } lsu_state_t;

  // funct3 access codes (loads use all five, stores use the first three)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size encoding carried in funct3[1:0]
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    if (is_store) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  // Only meaningful for legal codes; illegal codes are rejected by f3_legal.
  function automatic logic f3_aligned(input logic [1:0] size, input logic [1:0] lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~lo[0];
      default: ok = (lo == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] f3_byte_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lo;
      SZ_HALF: m = 4'b0011 << lo;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane extraction: picks byte/halfword lane from a read word and sign/zero extends it.
// Latency: combinational.
// Backpressure: none.
// Ports: word (read word), addr_lo (byte offset), funct3 (size/sign), result (formatted load value).
module load_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       addr_lo,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr_lo)
      2'b00:   w_byte = word[7:0];
      2'b01:   w_byte = word[15:8];
      2'b10:   w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    // Halfwords are always aligned here, so only addr_lo[1] selects the lane.
    w_half = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    result = {{(WIDTH-8){w_byte[7]}}, w_byte};
      F3_BU:   result = {{(WIDTH-8){1'b0}}, w_byte};
      F3_H:    result = {{(WIDTH-16){w_half[15]}}, w_half};
      F3_HU:   result = {{(WIDTH-16){1'b0}}, w_half};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: decodes a load/store, issues one word-aligned memory request, formats load data.
// Latency: done 2 cycles after start when mem_ready is immediate; a fault reports done/err 1 cycle after start.
// Backpressure: holds mem_* stable while mem_ready=0; busy stalls the pipeline and start is ignored while busy.
// Ports: clk, rst_n; start/is_store/funct3/addr/store_data from execute; busy/done/err/load_data to the pipeline;
//        mem_req/mem_we/mem_be/mem_addr/mem_wdata to memory, mem_ready/mem_rdata back from memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] load_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  lsu_state_t       r_state;
  lsu_state_t       w_next;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [1:0]       r_lane;
  logic [3:0]       r_be;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_load_data;
  logic             r_done;

  logic             w_legal;
  logic             w_aligned;
  logic             w_accept;
  logic             w_complete;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_fmt_data;

  assign w_legal   = f3_legal(is_store, funct3);
  assign w_aligned = f3_aligned(funct3[1:0], addr[1:0]);

  // Replicate the stored lane across the whole bus so memory can pick it by byte enable.
  always_comb begin
    w_wdata = store_data;
    case (funct3[1:0])
      SZ_BYTE: for (int i = 0; i < WIDTH / 8; i++)  w_wdata[8*i +: 8]   = store_data[7:0];
      SZ_HALF: for (int i = 0; i < WIDTH / 16; i++) w_wdata[16*i +: 16] = store_data[15:0];
      default: w_wdata = store_data;
    endcase
  end

  load_align #(
    .WIDTH(WIDTH)
  ) u_load_align (
    .word    (mem_rdata),
    .addr_lo (r_lane),
    .funct3  (r_funct3),
    .result  (w_fmt_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and control outputs
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_complete = 1'b0;
    busy       = 1'b1;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    err        = 1'b0;
    done       = r_done;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (w_legal && w_aligned) begin
            w_next   = ST_MEM;
            w_accept = 1'b1;
          end else begin
            w_next = ST_FAULT;
          end
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = r_we;
        if (mem_ready) begin
          w_next     = ST_IDLE;
          w_complete = 1'b1;
        end
      end
      ST_FAULT: begin
        err    = 1'b1;
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Request latch, completion pulse and load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_lane      <= 2'b00;
      r_be        <= 4'b0000;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_load_data <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_complete;
      if (w_accept) begin
        r_we     <= is_store;
        r_funct3 <= funct3;
        r_lane   <= addr[1:0];
        r_be     <= f3_byte_mask(funct3[1:0], addr[1:0]);
        r_addr   <= {addr[WIDTH-1:2], 2'b00};
        r_wdata  <= w_wdata;
      end
      // Only a completing load updates the result; stores and faults leave it alone.
      if (w_complete && !r_we) begin
        r_load_data <= w_fmt_data;
      end
    end
  end

  assign load_data = r_load_data;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_store = 1'b0;
  logic [2:0]   funct3 = 3'b000;
  logic [W-1:0] addr = '0;
  logic [W-1:0] store_data = '0;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] load_data;
  logic         mem_req;
  logic         mem_we;
  logic [3:0]   mem_be;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_ready = 1'b0;
  logic [W-1:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_load = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .load_data  (load_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One access, checked cycle by cycle against values derived from the access rules.
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] rd, input int dly,
                            input string tag);
    int          sz;
    int          off;
    bit          lg;
    bit          al;
    longint      v;
    logic [31:0] exp_ld;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    logic [3:0]  exp_be;
    lg = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    al = (off % sz) == 0;
    exp_addr = a & 32'hFFFF_FFFC;
    exp_be = 4'(((1 << sz) - 1) << off);
    if (sz == 1)      exp_wd = 32'({24'd0, sd[7:0]} * 32'h0101_0101);
    else if (sz == 2) exp_wd = 32'({16'd0, sd[15:0]} * 32'h0001_0001);
    else              exp_wd = sd;
    v = longint'(rd >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
    if (f3[2] == 1'b0 && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    exp_ld = v[31:0];

    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    tick();
    // scramble request inputs so only the latched copy can be correct
    start = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; store_data = $urandom;

    if (lg && al) begin
      for (int c = 0; c <= dly; c++) begin
        n_cmp++;
        if ({mem_req, busy, done, mem_we} !== {1'b1, 1'b1, 1'b0, st}) begin
          n_bad++;
          $display("FAIL %s ctl c%0d: req/busy/done/we=%b want %b", tag, c,
                   {mem_req, busy, done, mem_we}, {1'b1, 1'b1, 1'b0, st});
        end
        n_cmp++;
        if (mem_addr !== exp_addr) begin
          n_bad++;
          $display("FAIL %s mem_addr c%0d: got %h want %h", tag, c, mem_addr, exp_addr);
        end
        if (st) begin
          n_cmp++;
          if (mem_be !== exp_be) begin
            n_bad++;
            $display("FAIL %s mem_be c%0d: got %b want %b", tag, c, mem_be, exp_be);
          end
          n_cmp++;
          if (mem_wdata !== exp_wd) begin
            n_bad++;
            $display("FAIL %s mem_wdata c%0d: got %h want %h", tag, c, mem_wdata, exp_wd);
          end
        end
        mem_ready = (c == dly);
        mem_rdata = (c == dly) ? rd : $urandom;
        tick();
      end
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (!st) m_load = exp_ld;
      n_cmp++;
      if ({done, err, busy, mem_req} !== 4'b1000) begin
        n_bad++;
        $display("FAIL %s completion: done/err/busy/req=%b want 1000", tag,
                 {done, err, busy, mem_req});
      end
      n_cmp++;
      if (load_data !== m_load) begin
        n_bad++;
        $display("FAIL %s load_data: got %h want %h", tag, load_data, m_load);
      end
      tick();
      n_cmp++;
      if (done !== 1'b0) begin
        n_bad++;
        $display("FAIL %s done pulse length: done=%b want 0", tag, done);
      end
    end else begin
      n_cmp++;
      if ({mem_req, done, err, busy} !== 4'b0111) begin
        n_bad++;
        $display("FAIL %s fault: req/done/err/busy=%b want 0111", tag,
                 {mem_req, done, err, busy});
      end
      tick();
      n_cmp++;
      if ({busy, done, err, mem_req} !== 4'b0000) begin
        n_bad++;
        $display("FAIL %s after fault: busy/done/err/req=%b want 0000", tag,
                 {busy, done, err, mem_req});
      end
      n_cmp++;
      if (load_data !== m_load) begin
        n_bad++;
        $display("FAIL %s load_data after fault: got %h want %h", tag, load_data, m_load);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({busy, done, err, mem_req, mem_we} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset ctl: busy/done/err/req/we=%b want 00000",
               {busy, done, err, mem_req, mem_we});
    end
    n_cmp++;
    if ({mem_be, mem_addr, mem_wdata, load_data} !== '0) begin
      n_bad++;
      $display("FAIL reset data: be=%b addr=%h wdata=%h load=%h want all 0",
               mem_be, mem_addr, mem_wdata, load_data);
    end
    rst_n = 1'b1;
    m_load = 32'h0;
    tick();
  endtask

  task automatic test_lb_sign;
    run_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, "lb");
    n_cmp++;
    if (load_data !== 32'hFFFF_FF80) begin
      n_bad++;
      $display("FAIL lb value: got %h want ffffff80", load_data);
    end
  endtask

  task automatic test_lhu_wait;
    run_access(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_0000, 3, "lhu");
    n_cmp++;
    if (load_data !== 32'h0000_8001) begin
      n_bad++;
      $display("FAIL lhu value: got %h want 00008001", load_data);
    end
  endtask

  task automatic test_sb;
    run_access(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, $urandom, 0, "sb");
    n_cmp++;
    if (load_data !== 32'h0000_8001) begin
      n_bad++;
      $display("FAIL sb kept load_data: got %h want 00008001", load_data);
    end
    run_access(1'b1, 3'b001, 32'h0000_0202, 32'h1234_5678, $urandom, 1, "sh");
    run_access(1'b1, 3'b010, 32'h0000_0204, 32'hDEAD_BEEF, $urandom, 2, "sw");
  endtask

  task automatic test_faults;
    run_access(1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0, "lw_misaligned");
    run_access(1'b0, 3'b001, 32'h0000_0101, 32'h0, 32'h0, 0, "lh_misaligned");
    run_access(1'b1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 0, "store_illegal_f3");
    run_access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0, "load_illegal_f3");
  endtask

  task automatic test_busy_ignore;
    int txn;
    txn = 0;
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
    tick();
    for (int c = 1; c <= 4; c++) begin
      // keep offering a different legal request while the unit is busy
      start = (c < 4); is_store = 1'b1; funct3 = 3'b010; addr = 32'h80;
      n_cmp++;
      if (mem_addr !== 32'h40 || mem_req !== 1'b1) begin
        n_bad++;
        $display("FAIL busy_ignore hold c%0d: req=%b addr=%h want 1/00000040", c, mem_req, mem_addr);
      end
      mem_ready = (c == 4);
      mem_rdata = (c == 4) ? 32'h1234_5678 : $urandom;
      if (mem_req && mem_ready) txn++;
      tick();
    end
    mem_ready = 1'b0;
    m_load = 32'h1234_5678;
    n_cmp++;
    if (done !== 1'b1 || load_data !== m_load) begin
      n_bad++;
      $display("FAIL busy_ignore done: done=%b load=%h want 1/%h", done, load_data, m_load);
    end
    for (int c = 0; c < 3; c++) begin
      if (mem_req) txn++;
      tick();
    end
    n_cmp++;
    if (txn !== 1) begin
      n_bad++;
      $display("FAIL busy_ignore transactions: got %0d want 1", txn);
    end
  endtask

  task automatic test_reset_mid_mem;
    bit saw_done;
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h300; store_data = 32'hCAFE_F00D;
    tick();
    start = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid setup: mem_req=%b want 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    m_load = 32'h0;
    n_cmp++;
    if ({mem_req, mem_we, busy, done, err} !== 5'b00000) begin
      n_bad++;
      $display("FAIL rst_mid async ctl: req/we/busy/done/err=%b want 00000",
               {mem_req, mem_we, busy, done, err});
    end
    n_cmp++;
    if ({mem_be, mem_addr, mem_wdata, load_data} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid async data: be=%b addr=%h wdata=%h load=%h want all 0",
               mem_be, mem_addr, mem_wdata, load_data);
    end
    mem_ready = 1'b1;
    saw_done = 1'b0;
    tick();
    if (done) saw_done = 1'b1;
    mem_ready = 1'b0;
    // release mid-cycle with a request already waiting for the next edge
    #3;
    rst_n = 1'b1;
    start = 1'b1; is_store = 1'b0; funct3 = 3'b000; addr = 32'h305;
    if (done) saw_done = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid done pulse: saw done=%b want 0", saw_done);
    end
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h304) begin
      n_bad++;
      $display("FAIL first start after reset: req=%b addr=%h want 1/00000304", mem_req, mem_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_AB00;
    tick();
    mem_ready = 1'b0;
    m_load = 32'hFFFF_FFAB;
    n_cmp++;
    if (done !== 1'b1 || load_data !== m_load) begin
      n_bad++;
      $display("FAIL post-reset lb: done=%b load=%h want 1/%h", done, load_data, m_load);
    end
    tick();
  endtask

  task automatic test_random;
    for (int k = 0; k < 80; k++) begin
      run_access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 3)), "rand");
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

  initial begin
    test_reset();
    test_lb_sign();
    test_lhu_wait();
    test_sb();
    test_faults();
    test_busy_ignore();
    test_reset_mid_mem();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
